// File: rtl/gray_pkg.sv
// Shared constants and helpers for the grayscale stream path (mode codes, luma weights, channel replication).
package gray_pkg;

    localparam int MODE_AVG   = 0;
    localparam int MODE_LUMA  = 1;

    localparam int W0         = 77;
    localparam int W1         = 150;
    localparam int W2         = 29;
    localparam int LUMA_SHIFT = 8;

    localparam int MAX_CH_W   = 32;
    localparam int MAX_DW     = 256;

    // Callers size the result down to CH_WIDTH*NUM_CH with a cast.
    function automatic logic [MAX_DW-1:0] replicate(input logic [MAX_CH_W-1:0] val,
                                                    input int ch_width,
                                                    input int num_ch);
        logic [MAX_DW-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_DW; i++) begin
            if (i < ch_width * num_ch) begin
                r[i] = val[i % ch_width];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/gray_stream_conv_if.sv
// Input-FIFO read side and output-FIFO write side of the gray converter; master = converter, slave = FIFOs.
interface gray_stream_conv_if #(
    parameter int DWIDTH = 24
);
    logic [DWIDTH-1:0] in_dout;
    logic              in_empty;
    logic              in_rd_en;
    logic [DWIDTH-1:0] out_din;
    logic              out_full;
    logic              out_wr_en;

    modport master (
        input  in_dout, in_empty, out_full,
        output in_rd_en, out_din, out_wr_en
    );

    modport slave (
        output in_dout, in_empty, out_full,
        input  in_rd_en, out_din, out_wr_en
    );
endinterface

// File: rtl/gray_stream_conv_calc.sv
// Per-mode channel arithmetic: S1 registers the channel sum (average) or weighted sum (luma) when ld_i is high;
// gray_o is the combinational reduction of the S1 register, consumed by the caller's S2.
module gray_calc
    import gray_pkg::*;
#(
    parameter int CH_WIDTH = 8,
    parameter int NUM_CH   = 3,
    parameter int MODE     = MODE_AVG
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         ld_i,
    input  logic [CH_WIDTH*NUM_CH-1:0]   pix_i,
    output logic [CH_WIDTH-1:0]          gray_o
);
    localparam int ACC_W = (MODE == MODE_LUMA) ? CH_WIDTH + LUMA_SHIFT
                                               : CH_WIDTH + $clog2(NUM_CH);

    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] acc_q;

    if (MODE == MODE_LUMA) begin : g_luma
        if (NUM_CH != 3) begin : g_bad_luma
            $error("gray_calc: MODE_LUMA needs NUM_CH == 3");
        end
        always_comb begin
            acc_d = ACC_W'(W0) * ACC_W'(pix_i[CH_WIDTH-1:0])
                  + ACC_W'(W1) * ACC_W'(pix_i[2*CH_WIDTH-1:CH_WIDTH])
                  + ACC_W'(W2) * ACC_W'(pix_i[3*CH_WIDTH-1:2*CH_WIDTH]);
        end
        // Weights sum to 256, so the top CH_WIDTH bits can never overflow.
        assign gray_o = acc_q[ACC_W-1 -: CH_WIDTH];
    end else begin : g_avg
        always_comb begin
            acc_d = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                acc_d = acc_d + ACC_W'(pix_i[c*CH_WIDTH +: CH_WIDTH]);
            end
        end
        assign gray_o = CH_WIDTH'(acc_q / ACC_W'(NUM_CH));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else if (ld_i) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/gray_stream_conv.sv
// FWFT-in/FIFO-out colour-to-gray converter: 2-cycle latency, 1 pixel/clock; out_full stalls S2, then S1, then pops.
// Optional GRAY_BINARIZE_EN turns the gray value into all-ones/zero per channel against THRESHOLD.
module gray_stream_conv
    import gray_pkg::*;
#(
    parameter int CH_WIDTH     = 8,
    parameter int NUM_CH       = 3,
    parameter int MODE         = MODE_AVG,
    parameter int FRAME_PIXELS = 388800
`ifdef GRAY_BINARIZE_EN
    ,
    parameter int THRESHOLD    = 2 ** (CH_WIDTH - 1)
`endif
) (
    input  logic               clock,
    input  logic               reset,
    gray_stream_conv_if.master bus,
    output logic               frame_done,
    output logic               busy
);
    localparam int DWIDTH = CH_WIDTH * NUM_CH;
    localparam int CNT_W  = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

    if (FRAME_PIXELS < 1) begin : g_bad_frame
        $error("gray_stream_conv: FRAME_PIXELS must be >= 1");
    end

    logic              s1_v_d, s1_v_q;
    logic              s2_v_d, s2_v_q;
    logic [DWIDTH-1:0] dout_d, dout_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              done_d, done_q;
    logic              adv1, adv2, pop, push;
    logic [CH_WIDTH-1:0] gray;
    logic [CH_WIDTH-1:0] s2_val;

    // Handshakes are gated by reset so neither FIFO moves while the pipeline is being cleared.
    assign adv2 = ~s2_v_q | ~bus.out_full;
    assign adv1 = ~s1_v_q | adv2;
    assign pop  = ~reset & ~bus.in_empty & adv1;
    assign push = ~reset & s2_v_q & ~bus.out_full;

    assign bus.in_rd_en  = pop;
    assign bus.out_wr_en = push;
    assign bus.out_din   = dout_q;
    assign frame_done    = done_q;
    assign busy          = s1_v_q | s2_v_q;

    gray_calc #(
        .CH_WIDTH (CH_WIDTH),
        .NUM_CH   (NUM_CH),
        .MODE     (MODE)
    ) u_calc (
        .clk_i  (clock),
        .rst_i  (reset),
        .ld_i   (pop),
        .pix_i  (bus.in_dout),
        .gray_o (gray)
    );

`ifdef GRAY_BINARIZE_EN
    assign s2_val = (32'(gray) >= 32'(THRESHOLD)) ? '1 : '0;
`else
    assign s2_val = gray;
`endif

    always_comb begin
        s1_v_d = s1_v_q;
        s2_v_d = s2_v_q;
        dout_d = dout_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (adv1) begin
            s1_v_d = pop;
        end
        if (adv2) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                dout_d = DWIDTH'(replicate(MAX_CH_W'(s2_val), CH_WIDTH, NUM_CH));
            end
        end
        if (push) begin
            if (cnt_q == LAST_PIX) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            dout_q <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            s1_v_q <= s1_v_d;
            s2_v_q <= s2_v_d;
            dout_q <= dout_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

endmodule

// File: doc/gray_stream_conv.md
Name: gray_stream_conv

Overview:
- Streaming colour-to-grayscale converter between an input FWFT FIFO and an output FIFO inside dut_system.
- Parametrised successor of the fixed 24-bit RGB grayscale path: generalised channel width and count, selectable average/luma mode, frame pixel counter with end-of-frame pulse.
- Output word replicates the gray value on every channel, so the downstream BMP writer is unchanged.

Parameters:
- CH_WIDTH, 8, bits per colour channel.
- NUM_CH, 3, channels per pixel; DWIDTH = CH_WIDTH*NUM_CH.
- MODE, 0, 0 = floor(sum/NUM_CH); 1 = luma weights; MODE 1 legal only with NUM_CH==3.
- FRAME_PIXELS, 388800, pixels per frame (720x540); must be >= 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_dout  in  DWIDTH  input FIFO head word (FWFT: valid whenever in_empty=0).
- in_empty  in  1  input FIFO empty.
- in_rd_en  out  1  pop input FIFO this cycle.
- out_din  out  DWIDTH  gray pixel, replicated on all channels.
- out_full  in  1  output FIFO full.
- out_wr_en  out  1  push out_din this cycle.
- frame_done  out  1  one-cycle pulse on the write of the last pixel of a frame.
- busy  out  1  any pipeline stage holds a valid pixel.

Behaviour:
- Reset (one clock, reset=1): in_rd_en=0, out_wr_en=0, out_din=0, frame_done=0, busy=0, pixel counter=0, all stage valids=0. A pixel popped before reset is discarded.
- Pipeline: S1 registers products/channel sum; S2 registers the final gray value and out_din. Valid bits s1_v, s2_v.
- Handshake: out_wr_en = s2_v & ~out_full (combinational). adv2 = ~s2_v | ~out_full; adv1 = ~s1_v | adv2; in_rd_en = ~in_empty & adv1 (combinational).
- Latency: word popped at edge N is written at edge N+2 when there is no back-pressure. Sustained throughput is 1 pixel/clock.
- Stall: with out_full=1 and s2_v=1, S2 holds. S1 holds if valid. Input pops stop once both stages are full. No pixel is dropped or duplicated. Deassertion resumes in the same cycle.
- Channel c occupies in_dout[(c+1)*CH_WIDTH-1 : c*CH_WIDTH].
- MODE 0 arithmetic: sum is CH_WIDTH+$clog2(NUM_CH) bits, gray = floor(sum/NUM_CH) by constant divide; result always fits CH_WIDTH.
- MODE 1 arithmetic: gray = (W0*ch0 + W1*ch1 + W2*ch2) >> 8, using W0=77 (ch0, R), W1=150 (ch1, G), W2=29 (ch2, B). Accumulator is CH_WIDTH+8 bits. Weights sum to 256, so the result is at most 2^CH_WIDTH-1; no saturation is needed.
- Pixel counter: $clog2(FRAME_PIXELS) bits, increments on each out_wr_en. When the count is FRAME_PIXELS-1 and out_wr_en=1: frame_done=1 (registered, asserted the following cycle) and the counter wraps to 0.
- FRAME_PIXELS=1: frame_done pulses after every write.
- Simultaneous pop and push in one cycle are both honoured. in_empty toggling every cycle produces gaps in the output only, never corrupt data.
- busy = s1_v | s2_v.

Optional Feature:
- Macro GRAY_BINARIZE_EN.
- Defined: adds parameter THRESHOLD (default 2^(CH_WIDTH-1)). S2 outputs all-ones per channel if gray >= THRESHOLD, else 0. Latency and handshake unchanged.
- Undefined: plain gray output; THRESHOLD is absent.

Decomposition:
- Package gray_pkg:
  - MODE_AVG=0 and MODE_LUMA=1.
  - Luma weights W0/W1/W2 and LUMA_SHIFT=8.
  - Function replicating a CH_WIDTH value NUM_CH times.
- One sub-module, gray_calc: the combinational+S1 arithmetic per MODE. It keeps the handshake/counter shell small and allows reuse by later filter blocks.

Test Plan:
- MODE 0, single word 0x306090 written after reset, output never full -> out_wr_en at N+2 with out_din=0x606060; in_rd_en high exactly one cycle.
- MODE 1, input 0x0000FF (R=255) -> out_din=0x4C4C4C (77*255>>8=76); input 0xFFFFFF -> 0xFFFFFF; input 0x000000 -> 0x000000.
- Back-pressure: stream 10 distinct pixels, hold out_full=1 for 5 cycles mid-stream -> in_rd_en low once s1_v and s2_v are both set; all 10 outputs in order, no loss or duplication.
- Frame counter with FRAME_PIXELS=4: stream 9 pixels -> frame_done pulses after writes 4 and 8 only, and the counter reads 1 at the end.
- Reset mid-stream: assert reset with s1_v=s2_v=1 -> next cycle busy=0, out_wr_en=0, counter=0; the next input pixel is processed normally with latency 2.
- GRAY_BINARIZE_EN, THRESHOLD=128, MODE 0: input 0x7F7F7F -> 0x000000; input 0x808080 -> 0xFFFFFF.
